// File: rtl/uart_lite_axil_model.sv
// uart_lite_axil_model
// AXI4-Lite slave standing in for a UART Lite peripheral. A 16-byte register
// window at UART_BASE_ADDR exposes an RX FIFO (host -> design) and a TX FIFO
// (design -> host), a status word and a control word. The host side sees the
// TX FIFO head as a first-word-fall-through byte stream and pushes RX bytes
// through a valid/ready pair. intr_o pulses on rising rx_valid / tx_empty
// while interrupts are enabled.
//
// Ports
//   aclk, areset            clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*         AXI-Lite write channels (AW and W held independently)
//   s_axi_ar*/r*            AXI-Lite read channels
//   tx_data_o/tx_v_o/tx_ready_i   TX FIFO head, popped on tx_v_o & tx_ready_i
//   rx_data_i/rx_v_i/rx_ready_o   RX FIFO push, taken on rx_v_i & rx_ready_o
//   intr_o                  one-cycle interrupt pulse
module uart_lite_axil_model #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 28,
  parameter logic [31:0] UART_BASE_ADDR     = 32'h1100000,
  parameter int          FIFO_DEPTH         = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]                    s_axi_awprot,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]                    s_axi_arprot,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [7:0]                    tx_data_o,
  output logic                          tx_v_o,
  input  logic                          tx_ready_i,
  input  logic [7:0]                    rx_data_i,
  input  logic                          rx_v_i,
  output logic                          rx_ready_o,
  output logic                          intr_o
);

  localparam int                AW       = C_S_AXI_ADDR_WIDTH;
  localparam int                PW       = $clog2(FIFO_DEPTH);
  localparam logic [AW-5:0]     BASE_TAG = UART_BASE_ADDR[AW-1:4];
  localparam logic [PW:0]       PTR_ONE  = (PW+1)'(1);
  localparam logic [1:0]        RESP_OK  = 2'b00;
  localparam logic [1:0]        RESP_DEC = 2'b11;

  // ---------------------------------------------------------------------------
  // Write channel: one-entry holding registers for AW and W
  // ---------------------------------------------------------------------------
  logic          aw_held, w_held;
  logic [AW-1:0] aw_addr_q;
  logic [31:0]   w_data_q;
  logic [3:0]    w_strb_q;

  logic          aw_hs, w_hs, do_write;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          wr_hit;
  logic [1:0]    wr_off;

  assign s_axi_awready = !aw_held;
  assign s_axi_wready  = !w_held;
  assign aw_hs         = s_axi_awvalid & !aw_held;
  assign w_hs          = s_axi_wvalid & !w_held;

  // A beat arriving this cycle counts as held, so AW+W in the same cycle
  // execute immediately and bvalid shows up on the next edge.
  assign do_write = (aw_held | aw_hs) & (w_held | w_hs) & !s_axi_bvalid;
  assign wr_addr  = aw_held ? aw_addr_q : s_axi_awaddr;
  assign wr_data  = w_held  ? w_data_q  : s_axi_wdata;
  assign wr_strb  = w_held  ? w_strb_q  : s_axi_wstrb;
  assign wr_hit   = (wr_addr[AW-1:4] == BASE_TAG);
  assign wr_off   = wr_addr[3:2];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OK;
    end else begin
      if (do_write) begin
        aw_held <= 1'b0;
      end else if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (do_write) begin
        w_held <= 1'b0;
      end else if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (do_write) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_hit ? RESP_OK : RESP_DEC;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  logic tx_push, ctrl_wr, tx_flush, rx_flush;
  logic intr_en;

  assign tx_push  = do_write & wr_hit & (wr_off == 2'd1) & wr_strb[0];
  assign ctrl_wr  = do_write & wr_hit & (wr_off == 2'd3);
  assign tx_flush = ctrl_wr & wr_data[0];
  assign rx_flush = ctrl_wr & wr_data[1];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)       intr_en <= 1'b0;
    else if (ctrl_wr) intr_en <= wr_data[4];
  end

  // ---------------------------------------------------------------------------
  // FIFOs: PW+1 bit pointers, full when MSBs differ and the rest match
  // ---------------------------------------------------------------------------
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [PW:0] rx_wr, rx_rd, tx_wr, tx_rd;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push_ok, tx_pop;

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[PW] != rx_rd[PW]) && (rx_wr[PW-1:0] == rx_rd[PW-1:0]);
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[PW] != tx_rd[PW]) && (tx_wr[PW-1:0] == tx_rd[PW-1:0]);

  assign rx_ready_o = !rx_full;
  assign rx_push    = rx_v_i & rx_ready_o;
  assign tx_v_o     = !tx_empty;
  assign tx_data_o  = tx_mem[tx_rd[PW-1:0]];
  assign tx_pop     = tx_v_o & tx_ready_i;
  assign tx_push_ok = tx_push & !tx_full;

  // A flush takes priority over any push or pop landing in the same cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rx_wr <= '0;
      rx_rd <= '0;
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (rx_flush) begin
        rx_wr <= '0;
        rx_rd <= '0;
      end else begin
        if (rx_push) rx_wr <= rx_wr + PTR_ONE;
        if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
      end
      if (tx_flush) begin
        tx_wr <= '0;
        tx_rd <= '0;
      end else begin
        if (tx_push_ok) tx_wr <= tx_wr + PTR_ONE;
        if (tx_pop)     tx_rd <= tx_rd + PTR_ONE;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rx_push)    rx_mem[rx_wr[PW-1:0]] <= rx_data_i;
    if (tx_push_ok) tx_mem[tx_wr[PW-1:0]] <= wr_data[7:0];
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  logic        ar_hs, rd_hit;
  logic [1:0]  rd_off;
  logic [31:0] rd_word, stat_word;

  assign s_axi_arready = !s_axi_rvalid;
  assign ar_hs         = s_axi_arvalid & !s_axi_rvalid;
  assign rd_hit        = (s_axi_araddr[AW-1:4] == BASE_TAG);
  assign rd_off        = s_axi_araddr[3:2];
  assign rx_pop        = ar_hs & rd_hit & (rd_off == 2'd0) & !rx_empty;
  assign stat_word     = {27'b0, intr_en, tx_full, tx_empty, rx_full, !rx_empty};

  always_comb begin
    rd_word = 32'b0;
    if (rd_hit) begin
      case (rd_off)
        2'd0:    if (!rx_empty) rd_word = {24'b0, rx_mem[rx_rd[PW-1:0]]};
        2'd2:    rd_word = stat_word;
        default: rd_word = 32'b0;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OK;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_word;
      s_axi_rresp  <= rd_hit ? RESP_OK : RESP_DEC;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt: previous-value registers start at the reset-state status so no
  // pulse fires at reset release.
  // ---------------------------------------------------------------------------
  logic rx_valid_q, tx_empty_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rx_valid_q <= 1'b0;
      tx_empty_q <= 1'b1;
    end else begin
      rx_valid_q <= !rx_empty;
      tx_empty_q <= tx_empty;
    end
  end

  assign intr_o = intr_en & ((!rx_empty & !rx_valid_q) | (tx_empty & !tx_empty_q));

  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], s_axi_araddr[1:0],
                         wr_data[31:8], wr_data[3:2], wr_strb[3:1]};

endmodule

// File: tb/tb_uart_lite_axil_model.sv
module tb_uart_lite_axil_model;

  localparam logic [27:0] BASE = 28'h1100000;

  logic        aclk = 1'b0;
  logic        areset;
  logic [27:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [27:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [7:0]  tx_data_o;
  logic        tx_v_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_v_i;
  logic        rx_ready_o;
  logic        intr_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int intr_cnt     = 0;
  logic [7:0] tx_q[$];

  uart_lite_axil_model dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .tx_data_o(tx_data_o), .tx_v_o(tx_v_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_v_i(rx_v_i), .rx_ready_o(rx_ready_o),
    .intr_o(intr_o)
  );

  always #5 aclk = ~aclk;

  // Stream monitors sample mid-cycle; inputs only change 1ns after posedge.
  always @(negedge aclk) begin
    if (!areset && tx_v_o && tx_ready_i) tx_q.push_back(tx_data_o);
    if (!areset && intr_o) intr_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "global timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [27:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output bit ok);
    bit aw_done, w_done;
    int n;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    aw_done = 0; w_done = 0; ok = 0; resp = 2'b00; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge aclk);
      if (s_axi_awready) aw_done = 1;
      if (s_axi_wready)  w_done  = 1;
      @(posedge aclk); #1;
      if (aw_done) s_axi_awvalid = 1'b0;
      if (w_done)  s_axi_wvalid  = 1'b0;
      n++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!ok && n < 20) begin
      if (s_axi_bvalid) begin
        resp = s_axi_bresp;
        ok = 1;
      end
      step(1);
      n++;
    end
  endtask

  task automatic axi_read(input logic [27:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    bit ar_done;
    int n;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    ar_done = 0; ok = 0; data = '0; resp = 2'b00; n = 0;
    while (!ar_done && n < 20) begin
      @(negedge aclk);
      if (s_axi_arready) ar_done = 1;
      @(posedge aclk); #1;
      n++;
    end
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!ok && n < 20) begin
      if (s_axi_rvalid) begin
        data = s_axi_rdata;
        resp = s_axi_rresp;
        ok = 1;
      end
      step(1);
      n++;
    end
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data_i = b; rx_v_i = 1'b1;
    step(1);
    rx_v_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit ok;
    tests_run++;
    if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1 || s_axi_arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: aw/w/ar ready = %b%b%b, required 111", s_axi_awready, s_axi_wready, s_axi_arready);
    end
    tests_run++;
    if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_rdata !== 32'h0 ||
        s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_resp: bvalid=%b rvalid=%b rdata=%h bresp=%b rresp=%b, required all 0",
               s_axi_bvalid, s_axi_rvalid, s_axi_rdata, s_axi_bresp, s_axi_rresp);
    end
    tests_run++;
    if (tx_v_o !== 1'b0 || rx_ready_o !== 1'b1 || intr_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stream: tx_v=%b rx_ready=%b intr=%b, required 0 1 0", tx_v_o, rx_ready_o, intr_o);
    end
    axi_read(BASE + 28'h8, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h4 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_stat: ok=%0d stat=%h resp=%b, required stat 00000004 resp 00", ok, d, r);
    end
  endtask

  task automatic test_tx_path();
    logic [1:0] r1, r2; bit ok1, ok2;
    tx_q.delete();
    tx_ready_i = 1'b1;
    axi_write(BASE + 28'h4, 32'h41, 4'h1, r1, ok1);
    axi_write(BASE + 28'h4, 32'h42, 4'h1, r2, ok2);
    step(4);
    tests_run++;
    if (!ok1 || !ok2 || r1 !== 2'b00 || r2 !== 2'b00) begin
      tests_failed++;
      $display("FAIL tx_bresp: ok=%0d%0d bresp=%b/%b, required 11 00/00", ok1, ok2, r1, r2);
    end
    tests_run++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'h41 || tx_q[1] !== 8'h42) begin
      tests_failed++;
      $display("FAIL tx_order: got %0d bytes first=%h, required 2 bytes 41 42",
               tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_rx_path();
    logic [31:0] d; logic [1:0] r; bit ok;
    tx_ready_i = 1'b0;
    axi_write(BASE + 28'h4, 32'h99, 4'h1, r, ok);  // keep tx non-empty so STAT bit2 is 0
    rx_push(8'h55);
    tests_run++;
    if (tx_v_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rx_txhold: tx_v=%b, required 1", tx_v_o);
    end
    axi_read(BASE + 28'h8, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h1) begin
      tests_failed++;
      $display("FAIL rx_stat1: stat=%h, required 00000001", d);
    end
    axi_read(BASE, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h55 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL rx_read: data=%h resp=%b, required 00000055 00", d, r);
    end
    axi_read(BASE, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL rx_read_empty: data=%h, required 00000000", d);
    end
    axi_read(BASE + 28'h8, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL rx_stat0: stat=%h, required 00000000", d);
    end
    tx_ready_i = 1'b1;
    step(3);
    tx_ready_i = 1'b0;
    tx_q.delete();
  endtask

  task automatic test_tx_full();
    logic [31:0] d; logic [1:0] r; bit ok;
    int nresp;
    tx_ready_i = 1'b0;
    tx_q.delete();
    nresp = 0;
    for (int i = 0; i < 17; i++) begin
      axi_write(BASE + 28'h4, 32'(i), 4'h1, r, ok);
      if (ok && r == 2'b00) nresp++;
    end
    tests_run++;
    if (nresp != 17) begin
      tests_failed++;
      $display("FAIL txfull_bresp: okay responses=%0d, required 17", nresp);
    end
    axi_read(BASE + 28'h8, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h8) begin
      tests_failed++;
      $display("FAIL txfull_stat: stat=%h, required 00000008", d);
    end
    tx_ready_i = 1'b1;
    step(20);
    tx_ready_i = 1'b0;
    tests_run++;
    if (tx_q.size() != 16) begin
      tests_failed++;
      $display("FAIL txfull_count: drained=%0d, required 16", tx_q.size());
    end
    for (int i = 0; i < 16 && i < tx_q.size(); i++) begin
      tests_run++;
      if (tx_q[i] !== 8'(i)) begin
        tests_failed++;
        $display("FAIL txfull_byte%0d: got %h, required %h", i, tx_q[i], 8'(i));
      end
    end
    tx_q.delete();
  endtask

  task automatic test_rx_full();
    logic [31:0] d; logic [1:0] r; bit ok;
    for (int i = 0; i < 16; i++) begin
      rx_data_i = 8'hA0 + 8'(i); rx_v_i = 1'b1;
      step(1);
    end
    rx_v_i = 1'b0;
    tests_run++;
    if (rx_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rxfull_ready: rx_ready=%b, required 0", rx_ready_o);
    end
    axi_read(BASE + 28'h8, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h7) begin
      tests_failed++;
      $display("FAIL rxfull_stat: stat=%h, required 00000007", d);
    end
    // single AR at cycle N, rx_ready_o must come back at N+1
    s_axi_araddr = BASE; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    step(1);
    s_axi_arvalid = 1'b0;
    tests_run++;
    if (rx_ready_o !== 1'b1 || s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hA0) begin
      tests_failed++;
      $display("FAIL rxfull_pop: rx_ready=%b rvalid=%b rdata=%h, required 1 1 000000a0",
               rx_ready_o, s_axi_rvalid, s_axi_rdata);
    end
    step(1);
    for (int i = 1; i < 16; i++) begin
      axi_read(BASE, d, r, ok);
      tests_run++;
      if (!ok || d !== 32'hA0 + 32'(i)) begin
        tests_failed++;
        $display("FAIL rxfull_byte%0d: got %h, required %h", i, d, 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_intr_decode();
    logic [31:0] d; logic [1:0] r; bit ok;
    intr_cnt = 0;
    axi_write(BASE + 28'hC, 32'h10, 4'hF, r, ok);
    step(3);
    tests_run++;
    if (intr_cnt != 0) begin
      tests_failed++;
      $display("FAIL intr_enable_quiet: pulses=%0d, required 0", intr_cnt);
    end
    axi_read(BASE + 28'h8, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h14) begin
      tests_failed++;
      $display("FAIL intr_stat: stat=%h, required 00000014", d);
    end
    rx_push(8'h33);
    step(5);
    tests_run++;
    if (intr_cnt != 1) begin
      tests_failed++;
      $display("FAIL intr_rx_pulse: pulses=%0d, required 1", intr_cnt);
    end
    axi_read(BASE + 28'h10, d, r, ok);
    tests_run++;
    if (!ok || r !== 2'b11 || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL decode_read_miss: rresp=%b rdata=%h, required 11 00000000", r, d);
    end
    axi_write(BASE + 28'h14, 32'h5A, 4'h1, r, ok);
    tests_run++;
    if (!ok || r !== 2'b11 || tx_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL decode_write_miss: bresp=%b tx_v=%b, required 11 0", r, tx_v_o);
    end
    axi_read(BASE, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h33) begin
      tests_failed++;
      $display("FAIL intr_rx_data: data=%h, required 00000033", d);
    end
    tx_ready_i = 1'b0;
    axi_write(BASE + 28'h4, 32'h77, 4'h1, r, ok);
    axi_write(BASE + 28'hC, 32'h11, 4'hF, r, ok);  // flush TX, keep intr_en
    step(3);
    tests_run++;
    if (intr_cnt != 2 || tx_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL intr_tx_flush: pulses=%0d tx_v=%b, required 2 0", intr_cnt, tx_v_o);
    end
    axi_write(BASE + 28'hC, 32'h00, 4'hF, r, ok);
    axi_read(BASE + 28'h8, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h4) begin
      tests_failed++;
      $display("FAIL intr_disable_stat: stat=%h, required 00000004", d);
    end
  endtask

  task automatic test_channel_order();
    tx_ready_i = 1'b0;
    tx_q.delete();
    s_axi_bready = 1'b0;
    s_axi_awaddr = BASE + 28'h4;
    s_axi_wdata = 32'h61; s_axi_wstrb = 4'h1; s_axi_wvalid = 1'b1;
    step(1);
    s_axi_wvalid = 1'b0;
    step(2);
    tests_run++;
    if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL order_w_held: wready=%b bvalid=%b, required 0 0", s_axi_wready, s_axi_bvalid);
    end
    s_axi_awvalid = 1'b1;
    step(1);
    s_axi_awvalid = 1'b0;
    tests_run++;
    if (s_axi_bvalid !== 1'b1 || tx_v_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL order_bvalid: bvalid=%b tx_v=%b one cycle after AW, required 1 1", s_axi_bvalid, tx_v_o);
    end
    s_axi_wdata = 32'h62; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    step(1);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    step(2);
    tests_run++;
    if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL order_backpressure: awready=%b wready=%b bvalid=%b, required 0 0 1",
               s_axi_awready, s_axi_wready, s_axi_bvalid);
    end
    s_axi_bready = 1'b1;
    step(1);
    tests_run++;
    if (s_axi_bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL order_bhandshake: bvalid=%b, required 0", s_axi_bvalid);
    end
    step(1);
    tests_run++;
    if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin
      tests_failed++;
      $display("FAIL order_second_write: bvalid=%b awready=%b wready=%b, required 1 1 1",
               s_axi_bvalid, s_axi_awready, s_axi_wready);
    end
    step(1);
    tx_ready_i = 1'b1;
    step(4);
    tx_ready_i = 1'b0;
    tests_run++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'h61 || tx_q[1] !== 8'h62) begin
      tests_failed++;
      $display("FAIL order_tx_bytes: count=%0d first=%h, required 2 bytes 61 62",
               tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] r; bit ok;
    int pre;
    axi_write(BASE + 28'h4, 32'h3C, 4'h1, r, ok);
    pre = intr_cnt;
    s_axi_rready = 1'b0;
    s_axi_araddr = BASE + 28'h8; s_axi_arvalid = 1'b1;
    step(1);
    s_axi_arvalid = 1'b0;
    tests_run++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_pre_rvalid: rvalid=%b rdata=%h, required 1 00000000", s_axi_rvalid, s_axi_rdata);
    end
    #2 areset = 1'b1;
    #1;
    tests_run++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1 || tx_v_o !== 1'b0 || rx_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_async: rvalid=%b arready=%b tx_v=%b rx_ready=%b, required 0 1 0 1",
               s_axi_rvalid, s_axi_arready, tx_v_o, rx_ready_o);
    end
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    step(3);
    tests_run++;
    if (intr_cnt != pre || intr_o !== 1'b0 || s_axi_bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_release: new pulses=%0d intr=%b bvalid=%b, required 0 0 0",
               intr_cnt - pre, intr_o, s_axi_bvalid);
    end
  endtask

  initial begin
    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    tx_ready_i = 1'b0; rx_data_i = '0; rx_v_i = 1'b0;
    step(3);
    areset = 1'b0;
    step(2);
    test_reset();
    test_tx_path();
    test_rx_path();
    test_tx_full();
    test_rx_full();
    test_intr_decode();
    test_channel_order();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
